ysyx_rou_rob: RTL



---
 rtl/ysyx_rou_rob_if.sv | 34 +++
 rtl/ysyx_rou_rob.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/ysyx_rou_rob_if.sv
// Rename -> reorder dispatch channel: one renamed uop plus its operands and
// physical register tags, with a valid/ready handshake.
`ifndef YSYX_PHY_LEN
`define YSYX_PHY_LEN 6
`endif
`ifndef YSYX_XLEN
`define YSYX_XLEN 64
`endif

interface rnu_rou_if #(
  parameter int PLEN  = `YSYX_PHY_LEN,
  parameter int XLEN  = `YSYX_XLEN,
  parameter int UOP_W = 32
);
  logic [UOP_W-1:0] uop;
  logic [XLEN-1:0]  op1;
  logic [XLEN-1:0]  op2;
  logic [PLEN-1:0]  pr1;
  logic [PLEN-1:0]  pr2;
  logic [PLEN-1:0]  prd;
  logic [PLEN-1:0]  prs;
  logic             valid;
  logic             ready;

  modport master (
    output uop, op1, op2, pr1, pr2, prd, prs, valid,
    input  ready
  );

  modport slave (
    input  uop, op1, op2, pr1, pr2, prd, prs, valid,
    output ready
  );
endinterface

// File: rtl/ysyx_rou_rob.sv
// Reorder buffer front end: in-order allocation, out-of-order completion, in-order commit.
// Optional macro YSYX_ROU_FULL_BYPASS_EN lets a full ROB accept a dispatch in a commit cycle.
`ifndef YSYX_PHY_LEN
`define YSYX_PHY_LEN 6
`endif
`ifndef YSYX_XLEN
`define YSYX_XLEN 64
`endif

module ysyx_rou_rob #(
  parameter int PLEN     = `YSYX_PHY_LEN,
  parameter int XLEN     = `YSYX_XLEN,
  parameter int UOP_W    = 32,
  parameter int ROB_SIZE = 8,
  localparam int IW      = $clog2(ROB_SIZE)
) (
  input  logic             clock,
  input  logic             reset,
  rnu_rou_if.slave         rnu,
  output logic [IW-1:0]    disp_idx,
  input  logic             wb_valid,
  input  logic [IW-1:0]    wb_idx,
  input  logic [XLEN-1:0]  wb_data,
  output logic             cm_valid,
  input  logic             cm_ready,
  output logic [UOP_W-1:0] cm_uop,
  output logic [PLEN-1:0]  cm_prd,
  output logic [PLEN-1:0]  cm_prs,
  output logic [XLEN-1:0]  cm_data,
  output logic [XLEN-1:0]  cm_op1,
  output logic [XLEN-1:0]  cm_op2,
  input  logic             flush,
  output logic             empty
);

  localparam logic [IW:0]   FULL_CNT = (IW+1)'(ROB_SIZE);
  localparam logic [IW:0]   ZERO_CNT = (IW+1)'(0);
  localparam logic [IW:0]   ONE_CNT  = (IW+1)'(1);
  localparam logic [IW-1:0] ZERO_IDX = IW'(0);
  localparam logic [IW-1:0] ONE_IDX  = IW'(1);

  logic [UOP_W-1:0]    r_uop  [ROB_SIZE];
  logic [PLEN-1:0]     r_prd  [ROB_SIZE];
  logic [PLEN-1:0]     r_prs  [ROB_SIZE];
  logic [XLEN-1:0]     r_op1  [ROB_SIZE];
  logic [XLEN-1:0]     r_op2  [ROB_SIZE];
  logic [XLEN-1:0]     r_data [ROB_SIZE];
  logic [ROB_SIZE-1:0] r_busy;
  logic [ROB_SIZE-1:0] r_done;
  logic [IW-1:0]       r_head;
  logic [IW-1:0]       r_tail;
  logic [IW:0]         r_count;

  logic        w_cm_valid;
  logic        w_cm_fire;
  logic        w_ready;
  logic        w_disp_fire;
  logic [IW:0] w_count_nxt;
  logic        w_unused;

  // Source operand tags travel on the channel but are not kept in the ROB.
  assign w_unused = ^{rnu.pr1, rnu.pr2};

  assign w_cm_valid = r_busy[r_head] & r_done[r_head];
  assign w_cm_fire  = w_cm_valid & cm_ready;

`ifdef YSYX_ROU_FULL_BYPASS_EN
  // The slot freed by a commit is the tail slot when full, so it can be reused at once.
  assign w_ready = ((r_count != FULL_CNT) | w_cm_fire) & ~flush;
`else
  assign w_ready = (r_count != FULL_CNT) & ~flush;
`endif

  assign w_disp_fire = rnu.valid & w_ready;
  assign rnu.ready   = w_ready;

  // Occupancy update from this cycle's dispatch and commit.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_disp_fire, w_cm_fire})
      2'b10:   w_count_nxt = r_count + ONE_CNT;
      2'b01:   w_count_nxt = r_count - ONE_CNT;
      default: w_count_nxt = r_count;
    endcase
  end

  // Entry state, pointers and occupancy; dispatch is applied last so it wins over a
  // same-slot commit when the full bypass reuses the head entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_head  <= ZERO_IDX;
      r_tail  <= ZERO_IDX;
      r_count <= ZERO_CNT;
      r_busy  <= {ROB_SIZE{1'b0}};
      r_done  <= {ROB_SIZE{1'b0}};
      for (int i = 0; i < ROB_SIZE; i++) begin
        r_uop[i]  <= {UOP_W{1'b0}};
        r_prd[i]  <= {PLEN{1'b0}};
        r_prs[i]  <= {PLEN{1'b0}};
        r_op1[i]  <= {XLEN{1'b0}};
        r_op2[i]  <= {XLEN{1'b0}};
        r_data[i] <= {XLEN{1'b0}};
      end
    end else if (flush) begin
      r_head  <= ZERO_IDX;
      r_tail  <= ZERO_IDX;
      r_count <= ZERO_CNT;
      r_busy  <= {ROB_SIZE{1'b0}};
      r_done  <= {ROB_SIZE{1'b0}};
    end else begin
      if (wb_valid && r_busy[wb_idx]) begin
        r_done[wb_idx] <= 1'b1;
        r_data[wb_idx] <= wb_data;
      end
      if (w_cm_fire) begin
        r_busy[r_head] <= 1'b0;
        r_done[r_head] <= 1'b0;
        r_head         <= r_head + ONE_IDX;
      end
      if (w_disp_fire) begin
        r_busy[r_tail] <= 1'b1;
        r_done[r_tail] <= 1'b0;
        r_uop[r_tail]  <= rnu.uop;
        r_prd[r_tail]  <= rnu.prd;
        r_prs[r_tail]  <= rnu.prs;
        r_op1[r_tail]  <= rnu.op1;
        r_op2[r_tail]  <= rnu.op2;
        r_tail         <= r_tail + ONE_IDX;
      end
      r_count <= w_count_nxt;
    end
  end

  assign disp_idx = r_tail;
  assign empty    = (r_count == ZERO_CNT);
  assign cm_valid = w_cm_valid;
  assign cm_uop   = r_uop[r_head];
  assign cm_prd   = r_prd[r_head];
  assign cm_prs   = r_prs[r_head];
  assign cm_data  = r_data[r_head];
  assign cm_op1   = r_op1[r_head];
  assign cm_op2   = r_op2[r_head];

endmodule
